// File: rtl/snax_axi_host_loader.sv
// AXI4 master that turns a command stream plus a write-data stream into INCR bursts
// towards the SNAX host port; one transaction in flight, sticky error reporting.
module snax_axi_host_loader #(
    parameter logic [3:0] AxiId         = 4'h0,
    parameter logic [1:0] AxiUser       = 2'h0,
    parameter bit         CheckBoundary = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [47:0] cmd_addr_i,
    input  logic [7:0]  cmd_len_i,
    input  logic        wdata_valid_i,
    output logic        wdata_ready_o,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    output logic        rdata_valid_o,
    input  logic        rdata_ready_i,
    output logic [63:0] rdata_o,
    output logic        rdata_last_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    input  logic        err_clr_i,
    output logic [15:0] txn_cnt_o,
    output logic [3:0]  m_axi_awid_o,
    output logic [47:0] m_axi_awaddr_o,
    output logic [7:0]  m_axi_awlen_o,
    output logic [2:0]  m_axi_awsize_o,
    output logic [1:0]  m_axi_awburst_o,
    output logic        m_axi_awlock_o,
    output logic [3:0]  m_axi_awcache_o,
    output logic [2:0]  m_axi_awprot_o,
    output logic [3:0]  m_axi_awqos_o,
    output logic [3:0]  m_axi_awregion_o,
    output logic [1:0]  m_axi_awuser_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,
    output logic [63:0] m_axi_wdata_o,
    output logic [7:0]  m_axi_wstrb_o,
    output logic        m_axi_wlast_o,
    output logic [1:0]  m_axi_wuser_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,
    input  logic [3:0]  m_axi_bid_i,
    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o,
    output logic [3:0]  m_axi_arid_o,
    output logic [47:0] m_axi_araddr_o,
    output logic [7:0]  m_axi_arlen_o,
    output logic [2:0]  m_axi_arsize_o,
    output logic [1:0]  m_axi_arburst_o,
    output logic        m_axi_arlock_o,
    output logic [3:0]  m_axi_arcache_o,
    output logic [2:0]  m_axi_arprot_o,
    output logic [3:0]  m_axi_arqos_o,
    output logic [3:0]  m_axi_arregion_o,
    output logic [1:0]  m_axi_aruser_o,
    output logic        m_axi_arvalid_o,
    input  logic        m_axi_arready_i,
    input  logic [3:0]  m_axi_rid_i,
    input  logic [63:0] m_axi_rdata_i,
    input  logic [1:0]  m_axi_rresp_i,
    input  logic        m_axi_rlast_i,
    input  logic        m_axi_rvalid_i,
    output logic        m_axi_rready_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AW    = 3'd1,
        S_W     = 3'd2,
        S_B     = 3'd3,
        S_AR    = 3'd4,
        S_R     = 3'd5,
        S_DRAIN = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [47:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_q, beat_d;
    logic [15:0] txn_cnt_q, txn_cnt_d;
    logic        err_q;
    logic [1:0]  err_code_q;
    logic        err_set_s;
    logic [1:0]  err_new_s;
    logic        misalign_s;
    logic        cross_s;
    logic [13:0] end_off_s;
    logic        unused_s;

    assign misalign_s = (cmd_addr_i[2:0] != 3'b000);
    // Offset of the first byte past the burst within its 4 KiB page.
    assign end_off_s  = {2'b00, cmd_addr_i[11:0]} + {3'b000, cmd_len_i, 3'b000} + 14'd8;
    assign cross_s    = (CheckBoundary == 1'b1) && (end_off_s > 14'd4096);
    assign unused_s   = ^{m_axi_bid_i, m_axi_rid_i};

    assign m_axi_awid_o     = AxiId;
    assign m_axi_awaddr_o   = addr_q;
    assign m_axi_awlen_o    = len_q;
    assign m_axi_awsize_o   = 3'd3;
    assign m_axi_awburst_o  = 2'b01;
    assign m_axi_awlock_o   = 1'b0;
    assign m_axi_awcache_o  = 4'h0;
    assign m_axi_awprot_o   = 3'h0;
    assign m_axi_awqos_o    = 4'h0;
    assign m_axi_awregion_o = 4'h0;
    assign m_axi_awuser_o   = AxiUser;
    assign m_axi_wuser_o    = AxiUser;
    assign m_axi_arid_o     = AxiId;
    assign m_axi_araddr_o   = addr_q;
    assign m_axi_arlen_o    = len_q;
    assign m_axi_arsize_o   = 3'd3;
    assign m_axi_arburst_o  = 2'b01;
    assign m_axi_arlock_o   = 1'b0;
    assign m_axi_arcache_o  = 4'h0;
    assign m_axi_arprot_o   = 3'h0;
    assign m_axi_arqos_o    = 4'h0;
    assign m_axi_arregion_o = 4'h0;
    assign m_axi_aruser_o   = AxiUser;

    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign txn_cnt_o  = txn_cnt_q;

    // Next-state, counters and channel outputs.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        len_d           = len_q;
        beat_d          = beat_q;
        txn_cnt_d       = txn_cnt_q;
        err_set_s       = 1'b0;
        err_new_s       = 2'b00;
        cmd_ready_o     = 1'b0;
        wdata_ready_o   = 1'b0;
        rdata_valid_o   = 1'b0;
        rdata_o         = 64'h0;
        rdata_last_o    = 1'b0;
        m_axi_awvalid_o = 1'b0;
        m_axi_wvalid_o  = 1'b0;
        m_axi_wdata_o   = 64'h0;
        m_axi_wstrb_o   = 8'h00;
        m_axi_wlast_o   = 1'b0;
        m_axi_bready_o  = 1'b0;
        m_axi_arvalid_o = 1'b0;
        m_axi_rready_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = !rst_i;
                if (cmd_valid_i && !rst_i) begin
                    addr_d = cmd_addr_i;
                    len_d  = cmd_len_i;
                    beat_d = 8'd0;
                    if (misalign_s || cross_s) begin
                        err_set_s = 1'b1;
                        err_new_s = misalign_s ? 2'b10 : 2'b11;
                        state_d   = cmd_write_i ? S_DRAIN : S_IDLE;
                    end else begin
                        state_d = cmd_write_i ? S_AW : S_AR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                m_axi_awvalid_o = 1'b1;
                if (m_axi_awready_i) begin
                    state_d = S_W;
                end else begin
                    state_d = S_AW;
                end
            end
            S_W: begin
                m_axi_wvalid_o = wdata_valid_i;
                wdata_ready_o  = m_axi_wready_i;
                m_axi_wdata_o  = wdata_i;
                m_axi_wstrb_o  = wstrb_i;
                m_axi_wlast_o  = (beat_q == len_q);
                if (wdata_valid_i && m_axi_wready_i) begin
                    beat_d  = beat_q + 8'd1;
                    state_d = (beat_q == len_q) ? S_B : S_W;
                end else begin
                    state_d = S_W;
                end
            end
            S_B: begin
                m_axi_bready_o = 1'b1;
                if (m_axi_bvalid_i) begin
                    err_set_s = (m_axi_bresp_i != 2'b00);
                    err_new_s = 2'b01;
                    txn_cnt_d = txn_cnt_q + 16'd1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_B;
                end
            end
            S_AR: begin
                m_axi_arvalid_o = 1'b1;
                if (m_axi_arready_i) begin
                    state_d = S_R;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                rdata_valid_o  = m_axi_rvalid_i;
                m_axi_rready_o = rdata_ready_i;
                rdata_o        = m_axi_rdata_i;
                rdata_last_o   = m_axi_rlast_i;
                if (m_axi_rvalid_i && rdata_ready_i) begin
                    err_set_s = (m_axi_rresp_i != 2'b00);
                    err_new_s = 2'b01;
                    if (m_axi_rlast_i) begin
                        txn_cnt_d = txn_cnt_q + 16'd1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_R;
                    end
                end else begin
                    state_d = S_R;
                end
            end
            S_DRAIN: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    beat_d  = beat_q + 8'd1;
                    state_d = (beat_q == len_q) ? S_IDLE : S_DRAIN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, command and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= 48'h0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            txn_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    // Sticky error: first error since the last clear is kept; a clear beats a same-cycle error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else if (err_clr_i) begin
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else if (err_set_s && !err_q) begin
            err_q      <= 1'b1;
            err_code_q <= err_new_s;
        end else begin
            err_q      <= err_q;
            err_code_q <= err_code_q;
        end
    end

endmodule
